// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline control blocks: sequencing
// states and the NOP word loaded into flushed pipeline registers.
package mips_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } state_e;

  // sll $0,$0,0 -- all control bits zero, so a flushed stage does nothing.
  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

endpackage

// File: rtl/hazard_stall_control_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr)
      count_d = '0;
    else if (inc && !(&count_q))
      count_d = count_q + 1'b1;
  end

  always_ff @(posedge clk)
    count_q <= count_d;

  assign count = count_q;

endmodule

// File: rtl/hazard_stall_control.sv
// Pipeline sequencing for the 5-stage MIPS core: load-use bubbles, branch
// flushes, data-memory wait freezes with timeout, and stall/flush statistics.
module hazard_stall_control
  import mips_pkg::*;
#(
  parameter int CNT_WIDTH   = 16,
  parameter int MEM_TIMEOUT = 64,
  parameter int TO_WIDTH    = 8
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic [4:0]           Rs_ID,
  input  logic [4:0]           Rt_ID,
  input  logic                 UsesRs_ID,
  input  logic                 UsesRt_ID,
  input  logic                 MemRead_EX,
  input  logic [4:0]           WriteRegAddress_EX,
  input  logic                 BranchTaken_EX,
  input  logic                 MemReq_MEM,
  input  logic                 MemReady_MEM,
  output logic                 PCWrite,
  output logic                 IFIDWrite,
  output logic                 IDEXWrite,
  output logic                 EXMEMWrite,
  output logic                 IFIDFlush,
  output logic                 IDEXFlush,
  output logic                 MEMWBBubble,
  output logic [CNT_WIDTH-1:0] StallCycles,
  output logic [CNT_WIDTH-1:0] FlushCount,
  output logic                 MemError
);

  state_e              state_q, state_d;
  logic [TO_WIDTH-1:0] to_cnt_q, to_cnt_d, to_cnt_inc;
  logic                err_q, err_d;
  logic                mem_stall, load_use;
  logic                freeze, run_eval, flush_ev;

  assign mem_stall  = MemReq_MEM & ~MemReady_MEM;
  assign load_use   = MemRead_EX && (WriteRegAddress_EX != 5'd0) &&
                      ((UsesRs_ID && (Rs_ID == WriteRegAddress_EX)) ||
                       (UsesRt_ID && (Rt_ID == WriteRegAddress_EX)));
  assign to_cnt_inc = to_cnt_q + 1'b1;

  // Next-state and timeout tracking
  always_comb begin
    state_d  = state_q;
    to_cnt_d = to_cnt_q;
    err_d    = err_q;
    freeze   = 1'b0;
    run_eval = 1'b0;
    if (Reset) begin
      state_d  = RUN;
      to_cnt_d = '0;
      err_d    = 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          if (mem_stall) begin
            freeze   = 1'b1;
            to_cnt_d = TO_WIDTH'(1);
            if (MEM_TIMEOUT <= 1) begin
              state_d = ERROR;
              err_d   = 1'b1;
            end else begin
              state_d = MEM_WAIT;
            end
          end else begin
            run_eval = 1'b1;
          end
        end
        MEM_WAIT: begin
          if (mem_stall) begin
            freeze   = 1'b1;
            to_cnt_d = to_cnt_inc;
            if (to_cnt_inc >= TO_WIDTH'(MEM_TIMEOUT)) begin
              state_d = ERROR;
              err_d   = 1'b1;
            end
          end else begin
            run_eval = 1'b1;
            state_d  = RUN;
          end
        end
        default: freeze = 1'b1;
      endcase
    end
  end

  // Mealy outputs; reset drives every enable and flush so all stages clear.
  always_comb begin
    PCWrite     = 1'b1;
    IFIDWrite   = 1'b1;
    IDEXWrite   = 1'b1;
    EXMEMWrite  = 1'b1;
    IFIDFlush   = 1'b0;
    IDEXFlush   = 1'b0;
    MEMWBBubble = 1'b0;
    flush_ev    = 1'b0;
    if (Reset) begin
      IFIDFlush   = 1'b1;
      IDEXFlush   = 1'b1;
      MEMWBBubble = 1'b1;
    end else if (freeze) begin
      PCWrite     = 1'b0;
      IFIDWrite   = 1'b0;
      IDEXWrite   = 1'b0;
      EXMEMWrite  = 1'b0;
      MEMWBBubble = 1'b1;
    end else if (run_eval) begin
      // A taken branch squashes the ID instruction, so its load-use is moot.
      if (BranchTaken_EX) begin
        IFIDFlush = 1'b1;
        IDEXFlush = 1'b1;
        flush_ev  = 1'b1;
      end else if (load_use) begin
        PCWrite   = 1'b0;
        IFIDWrite = 1'b0;
        IDEXFlush = 1'b1;
      end
    end
  end

  always_ff @(posedge Clock) begin
    state_q  <= state_d;
    to_cnt_q <= to_cnt_d;
    err_q    <= err_d;
  end

  assign MemError = err_q;

  sat_counter #(.WIDTH(CNT_WIDTH)) u_stall_cnt (
    .clk   (Clock),
    .clr   (Reset),
    .inc   (~PCWrite & ~Reset),
    .count (StallCycles)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_flush_cnt (
    .clk   (Clock),
    .clr   (Reset),
    .inc   (flush_ev),
    .count (FlushCount)
  );

endmodule

// File: tb/tb_hazard_stall_control.sv
// Directed-vector bench for hazard_stall_control with small counters and a
// short memory timeout so saturation and the error path are reachable.
module tb_hazard_stall_control;

  localparam int CW = 2;

  // {PCWrite,IFIDWrite,IDEXWrite,EXMEMWrite,IFIDFlush,IDEXFlush,MEMWBBubble}
  localparam logic [6:0] O_DEF = 7'b1111_000;
  localparam logic [6:0] O_LU  = 7'b0011_010;
  localparam logic [6:0] O_BR  = 7'b1111_110;
  localparam logic [6:0] O_FRZ = 7'b0000_001;
  localparam logic [6:0] O_RST = 7'b1111_111;

  logic          Clock = 1'b0;
  logic          Reset;
  logic [4:0]    Rs_ID, Rt_ID, WriteRegAddress_EX;
  logic          UsesRs_ID, UsesRt_ID, MemRead_EX, BranchTaken_EX;
  logic          MemReq_MEM, MemReady_MEM;
  logic          PCWrite, IFIDWrite, IDEXWrite, EXMEMWrite;
  logic          IFIDFlush, IDEXFlush, MEMWBBubble, MemError;
  logic [CW-1:0] StallCycles, FlushCount;
  logic [6:0]    outs;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 Clock = ~Clock;

  hazard_stall_control #(.CNT_WIDTH(CW), .MEM_TIMEOUT(4), .TO_WIDTH(3)) dut (
    .Clock(Clock), .Reset(Reset), .Rs_ID(Rs_ID), .Rt_ID(Rt_ID),
    .UsesRs_ID(UsesRs_ID), .UsesRt_ID(UsesRt_ID), .MemRead_EX(MemRead_EX),
    .WriteRegAddress_EX(WriteRegAddress_EX), .BranchTaken_EX(BranchTaken_EX),
    .MemReq_MEM(MemReq_MEM), .MemReady_MEM(MemReady_MEM),
    .PCWrite(PCWrite), .IFIDWrite(IFIDWrite), .IDEXWrite(IDEXWrite),
    .EXMEMWrite(EXMEMWrite), .IFIDFlush(IFIDFlush), .IDEXFlush(IDEXFlush),
    .MEMWBBubble(MEMWBBubble), .StallCycles(StallCycles),
    .FlushCount(FlushCount), .MemError(MemError)
  );

  assign outs = {PCWrite, IFIDWrite, IDEXWrite, EXMEMWrite,
                 IFIDFlush, IDEXFlush, MEMWBBubble};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic idle();
    Rs_ID = 5'd0; Rt_ID = 5'd0; WriteRegAddress_EX = 5'd0;
    UsesRs_ID = 1'b0; UsesRt_ID = 1'b0; MemRead_EX = 1'b0;
    BranchTaken_EX = 1'b0; MemReq_MEM = 1'b0; MemReady_MEM = 1'b0;
  endtask

  task automatic set_lu(input logic [4:0] wr, input logic [4:0] rs, input logic urs,
                        input logic [4:0] rt, input logic urt);
    MemRead_EX = 1'b1; WriteRegAddress_EX = wr;
    Rs_ID = rs; UsesRs_ID = urs; Rt_ID = rt; UsesRt_ID = urt;
  endtask

  // Check combinational outputs mid-cycle, then advance past the next edge.
  task automatic cyc(input string tag, input logic [6:0] exp);
    @(negedge Clock);
    chk(tag, 32'(outs), 32'(exp));
    @(posedge Clock);
    #1;
  endtask

  task automatic do_reset(input string tag);
    Reset = 1'b1;
    cyc(tag, O_RST);
    Reset = 1'b0;
    idle();
  endtask

  task automatic chk_stats(input string tag, input int st, input int fl, input logic er);
    chk({tag, "_stall"}, 32'(StallCycles), 32'(st));
    chk({tag, "_flush"}, 32'(FlushCount), 32'(fl));
    chk({tag, "_err"}, 32'(MemError), 32'(er));
  endtask

  initial begin
    Reset = 1'b1;
    idle();
    @(posedge Clock); #1;
    do_reset("rst_outs");
    chk_stats("rst", 0, 0, 1'b0);

    // 1: load-use on Rs, exactly one bubble
    set_lu(5'd5, 5'd5, 1'b1, 5'd0, 1'b0);
    cyc("lu_rs", O_LU);
    MemRead_EX = 1'b0;
    cyc("lu_after", O_DEF);
    chk_stats("t1", 1, 0, 1'b0);

    // 2: $0 destination and unused Rs never stall; Rt match does
    set_lu(5'd0, 5'd0, 1'b1, 5'd0, 1'b1);
    cyc("lu_r0", O_DEF);
    set_lu(5'd5, 5'd5, 1'b0, 5'd7, 1'b1);
    cyc("lu_unused", O_DEF);
    set_lu(5'd9, 5'd1, 1'b1, 5'd9, 1'b1);
    cyc("lu_rt", O_LU);
    idle();
    cyc("t2_idle", O_DEF);
    chk_stats("t2", 2, 0, 1'b0);

    // 3: branch overrides load-use
    do_reset("rst3");
    set_lu(5'd5, 5'd5, 1'b1, 5'd0, 1'b0);
    BranchTaken_EX = 1'b1;
    cyc("br_lu", O_BR);
    idle();
    cyc("t3_idle", O_DEF);
    chk_stats("t3", 0, 1, 1'b0);

    // 4: three wait cycles, then ready with a branch evaluated as in RUN
    do_reset("rst4");
    MemReq_MEM = 1'b1; MemReady_MEM = 1'b0;
    for (int i = 0; i < 3; i++) cyc($sformatf("wait%0d", i), O_FRZ);
    MemReady_MEM = 1'b1; BranchTaken_EX = 1'b1;
    cyc("wait_ready", O_BR);
    BranchTaken_EX = 1'b0;
    cyc("req_ready_run", O_DEF);
    chk_stats("t4", 3, 1, 1'b0);

    // 5: timeout after four stalled cycles, error sticks until reset
    do_reset("rst5");
    MemReq_MEM = 1'b1; MemReady_MEM = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc($sformatf("to_frz%0d", i), O_FRZ);
      chk($sformatf("to_err%0d", i), 32'(MemError), 32'(i == 3));
    end
    MemReady_MEM = 1'b1;
    cyc("err_hold0", O_FRZ);
    idle();
    cyc("err_hold1", O_FRZ);
    chk_stats("t5", 3, 0, 1'b1);
    do_reset("rst_from_err");
    chk_stats("t5_clr", 0, 0, 1'b0);
    cyc("t5_run", O_DEF);

    // 6: reset mid-wait, then counter saturation
    MemReq_MEM = 1'b1; MemReady_MEM = 1'b0;
    cyc("mid_w0", O_FRZ);
    cyc("mid_w1", O_FRZ);
    do_reset("rst_mid");
    chk_stats("t6_clr", 0, 0, 1'b0);
    MemReq_MEM = 1'b1; MemReady_MEM = 1'b1;
    cyc("t6_run", O_DEF);
    idle();
    set_lu(5'd3, 5'd3, 1'b1, 5'd0, 1'b0);
    for (int i = 0; i < 5; i++) cyc($sformatf("sat_lu%0d", i), O_LU);
    idle();
    BranchTaken_EX = 1'b1;
    for (int i = 0; i < 5; i++) cyc($sformatf("sat_br%0d", i), O_BR);
    idle();
    chk_stats("t6_sat", 3, 3, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
